// File: rtl/adder_arbiter_pkg.sv
// Shared types and defaults for the FP16 adder arbiter slice (package adder_arb_pkg).
// The optional statistics feature is enabled with ADDER_ARB_STATS_EN.
package adder_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int DATA_W_DEF  = 16;
  localparam int ADD_LAT_DEF = 2;
  localparam int IDX_MAX_W   = 3;

  typedef logic [DATA_W_DEF-1:0] word_t;

  typedef struct packed {
    logic                 vld;
    logic [IDX_MAX_W-1:0] idx;
  } tag_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [7:0] idx_onehot(input logic [IDX_MAX_W-1:0] idx);
    return 8'(8'd1 << idx);
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Issue/result bus between the arbiter and the shared pipelined FP16 adder.
interface adder_if #(parameter int DATA_W = 16);
  logic              start;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] result;

  modport master (output start, output in1, output in2, input result);
  modport adder  (output start, output in1, output in2, input result);
  modport slave  (input start, input in1, input in2, output result);
endinterface

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  // Rotating priority search starting at ptr
  always_comb begin
    int   j;
    logic hit;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    hit     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j       = (int'(ptr) + k) % NREQ;
      hit     = en & ~gnt_vld & req[j];
      gnt[j]  = gnt[j] | hit;
      gnt_idx = hit ? IW'(j) : gnt_idx;
      gnt_vld = gnt_vld | hit;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one pipelined FP16 adder among NREQ requesters, with tag tracking
// and a drain/flush handshake. Define ADDER_ARB_STATS_EN to add per-requester issue counters.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_in1,
  input  logic [NREQ*DATA_W-1:0] req_in2,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_result,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic                   busy,
`ifdef ADDER_ARB_STATS_EN
  output logic [NREQ*16-1:0]     issue_cnt,
`endif
  adder_if.adder                 adder
);

  localparam int IW = $clog2(NREQ);

  state_t                     state_r, state_s;
  logic   [IW-1:0]            rr_ptr_r;
  tag_t   [ADD_LAT-1:0]       pipe_r;
  logic   [IW-1:0]            gnt_idx_s;
  logic                       gnt_vld_s;
  logic                       pipe_any_s;
  logic                       head_any_s;
  logic   [DATA_W-1:0]        in1_s, in2_s;
  tag_t                       last_s;

  // Grants are suppressed outside RUN and while reset is held
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .en      ((state_r == RUN) & nRST),
    .req     (req_valid),
    .ptr     (rr_ptr_r),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx_s),
    .gnt_vld (gnt_vld_s)
  );

  // Operand mux for the granted requester
  always_comb begin
    in1_s = '0;
    in2_s = '0;
    if (gnt_vld_s) begin
      in1_s = req_in1[int'(gnt_idx_s)*DATA_W +: DATA_W];
      in2_s = req_in2[int'(gnt_idx_s)*DATA_W +: DATA_W];
    end else begin
      in1_s = '0;
      in2_s = '0;
    end
  end

  assign adder.start = gnt_vld_s;
  assign adder.in1   = in1_s;
  assign adder.in2   = in2_s;

  // Round-robin pointer and tag shift register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr_r <= '0;
      pipe_r   <= '0;
    end else begin
      if (gnt_vld_s) begin
        rr_ptr_r <= (gnt_idx_s == IW'(NREQ-1)) ? '0 : gnt_idx_s + IW'(1);
      end
      pipe_r[0].vld <= gnt_vld_s;
      pipe_r[0].idx <= IDX_MAX_W'(gnt_idx_s);
      for (int i = 1; i < ADD_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Occupancy; head_any excludes the final stage, which empties this cycle
  always_comb begin
    pipe_any_s = 1'b0;
    head_any_s = 1'b0;
    for (int i = 0; i < ADD_LAT; i++) begin
      pipe_any_s = pipe_any_s | pipe_r[i].vld;
    end
    for (int i = 0; i < ADD_LAT-1; i++) begin
      head_any_s = head_any_s | pipe_r[i].vld;
    end
  end

  // Result routing from the last tag stage
  always_comb begin
    last_s = pipe_r[ADD_LAT-1];
    if (last_s.vld) begin
      rsp_valid  = NREQ'(idx_onehot(last_s.idx));
      rsp_result = adder.result;
    end else begin
      rsp_valid  = '0;
      rsp_result = '0;
    end
  end

  // Flush FSM state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= RUN;
    end else begin
      state_r <= state_s;
    end
  end

  // Flush FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      RUN:     state_s = flush_req ? DRAIN : RUN;
      DRAIN:   state_s = head_any_s ? DRAIN : DONE;
      DONE:    state_s = RUN;
      default: state_s = RUN;
    endcase
  end

  assign flush_done = (state_r == DONE);
  assign busy       = pipe_any_s | (state_r != RUN);

`ifdef ADDER_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_r;

  // Saturating per-requester issue counters, cleared on flush completion
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_r <= '0;
    end else if (state_r == DONE) begin
      cnt_r <= '0;
    end else if (gnt_vld_s && (cnt_r[gnt_idx_s] != 16'hFFFF)) begin
      cnt_r[gnt_idx_s] <= cnt_r[gnt_idx_s] + 16'd1;
    end
  end

  assign issue_cnt = cnt_r;
`endif

endmodule
